// File: rtl/rx_pkg.sv
// Shared types for the UART receive datapath: parity modes, frame FSM states
// and the bit-counter width.
package rx_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    LOAD  = 2'b10
  } rx_state_t;

  localparam int CNT_BITS = 4;

  // The unused 2'b11 encoding behaves as "no parity".
  function automatic parity_mode_t decode_parity(input logic [1:0] raw);
    case (raw)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear; after reaching rollover_val the
// next enabled increment wraps to 1.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] count_q;
  logic [NUM_CNT_BITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? NUM_CNT_BITS'(1) : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/rx_frame_sr.sv
// Receive-frame shift register: collects an LSB-first UART frame on bit-centre
// strobes, checks parity/stop and holds the result with ready/overrun tracking.
module rx_frame_sr
  import rx_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 shift_strobe,
  input  logic                 serial_in,
  input  logic                 frame_start,
  input  logic [1:0]           parity_mode,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 frame_done
);

  localparam int W = DATA_BITS + 2;

  rx_state_t           state_q;
  parity_mode_t        mode_q;
  logic [W-1:0]        sr_q;
  logic                frame_done_q;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 ready_q, ready_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic [CNT_BITS-1:0]  bit_cnt;
  logic [CNT_BITS-1:0]  frame_len;
  logic                 par_en;
  logic                 shift_en;
  logic                 last_bit;

  logic [DATA_BITS-1:0] fr_data;
  logic                 fr_par;
  logic                 fr_stop;
  logic                 fr_perr;

  assign par_en    = (mode_q != PAR_NONE);
  assign frame_len = CNT_BITS'(DATA_BITS + 1) + {{(CNT_BITS-1){1'b0}}, par_en};
  // frame_start outranks a coincident strobe, so that strobe must not count.
  assign shift_en  = shift_strobe && (state_q == SHIFT) && !frame_start;
  assign last_bit  = shift_en && (bit_cnt == frame_len - 1'b1);

  flex_counter #(
    .NUM_CNT_BITS(CNT_BITS)
  ) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (frame_start),
    .count_enable (shift_en),
    .rollover_val (frame_len),
    .count_out    (bit_cnt)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      mode_q       <= PAR_NONE;
      sr_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= (state_q == LOAD);
      if (frame_start) begin
        sr_q    <= '0;
        mode_q  <= decode_parity(parity_mode);
        state_q <= SHIFT;
      end else begin
        case (state_q)
          IDLE: state_q <= IDLE;
          SHIFT: begin
            if (shift_strobe) begin
              sr_q <= {serial_in, sr_q[W-1:1]};
              if (last_bit) begin
                state_q <= LOAD;
              end
            end
          end
          LOAD:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Without parity the frame is one bit shorter, so it sits one place higher.
  always_comb begin
    fr_stop = sr_q[W-1];
    if (par_en) begin
      fr_data = sr_q[W-3:0];
      fr_par  = sr_q[W-2];
    end else begin
      fr_data = sr_q[W-2:1];
      fr_par  = 1'b0;
    end
    case (mode_q)
      PAR_EVEN: fr_perr = (^fr_data) ^ fr_par;
      PAR_ODD:  fr_perr = ~((^fr_data) ^ fr_par);
      default:  fr_perr = 1'b0;
    endcase
  end

  always_comb begin
    rx_data_d = rx_data_q;
    ready_d   = ready_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    if (data_read && ready_q) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (state_q == LOAD) begin
      if (!ready_d) begin
        rx_data_d = fr_data;
        perr_d    = fr_perr;
        ferr_d    = !fr_stop;
        ready_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data_q <= '0;
      ready_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      ready_q   <= ready_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign data_ready    = ready_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign overrun_error = ovr_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_rx_frame_sr.sv
// Bench for rx_frame_sr: an 8-bit and a 5-bit instance driven with directed and
// random frames, checked against a frame-level model of the holding register.
`timescale 1ns/1ps
module tb_rx_frame_sr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst;
  logic       fs[2];
  logic       ss[2];
  logic       si[2];
  logic       rd[2];
  logic [1:0] pm[2];

  logic [7:0] rxd8;
  logic [4:0] rxd5;
  logic       rdy[2];
  logic       perr[2];
  logic       ferr[2];
  logic       ovr[2];
  logic       fd[2];

  rx_frame_sr #(.DATA_BITS(8)) dut8 (
    .clk(clk), .n_rst(n_rst), .shift_strobe(ss[0]), .serial_in(si[0]),
    .frame_start(fs[0]), .parity_mode(pm[0]), .data_read(rd[0]),
    .rx_data(rxd8), .data_ready(rdy[0]), .parity_error(perr[0]),
    .framing_error(ferr[0]), .overrun_error(ovr[0]), .frame_done(fd[0])
  );

  rx_frame_sr #(.DATA_BITS(5)) dut5 (
    .clk(clk), .n_rst(n_rst), .shift_strobe(ss[1]), .serial_in(si[1]),
    .frame_start(fs[1]), .parity_mode(pm[1]), .data_read(rd[1]),
    .rx_data(rxd5), .data_ready(rdy[1]), .parity_error(perr[1]),
    .framing_error(ferr[1]), .overrun_error(ovr[1]), .frame_done(fd[1])
  );

  int tests_run = 0;
  int fails     = 0;

  // Reference model: holding-register contents per instance.
  logic [8:0] e_data[2];
  bit         e_rdy[2];
  bit         e_perr[2];
  bit         e_ferr[2];
  bit         e_ovr[2];
  int         e_done[2];
  int         done_cnt[2];

  initial begin
    done_cnt[0] = 0;
    done_cnt[1] = 0;
  end

  always @(negedge clk) begin
    if (fd[0]) done_cnt[0]++;
    if (fd[1]) done_cnt[1]++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] get_rx(input int s);
    return (s == 0) ? {1'b0, rxd8} : {4'b0, rxd5};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      e_data[s] = '0;
      e_rdy[s]  = 0;
      e_perr[s] = 0;
      e_ferr[s] = 0;
      e_ovr[s]  = 0;
    end
  endtask

  task automatic check_outputs(input int s, input string tag);
    check_val({tag, ".data"}, get_rx(s), e_data[s]);
    check_val({tag, ".ready"}, rdy[s], e_rdy[s]);
    check_val({tag, ".perr"}, perr[s], e_perr[s]);
    check_val({tag, ".ferr"}, ferr[s], e_ferr[s]);
    check_val({tag, ".ovr"}, ovr[s], e_ovr[s]);
  endtask

  task automatic send_frame(input int s, input logic [8:0] data_in, input logic [1:0] mode,
                            input bit pflip, input bit stop, input bit rd_load,
                            input bit bb, input logic [1:0] bb_mode, input bit started);
    int         db;
    logic [8:0] data;
    bit         has_par;
    bit         pbit;
    bit         bits[$];
    db      = (s == 0) ? 8 : 5;
    data    = data_in & ((9'h1 << db) - 9'h1);
    has_par = (mode == 2'b01) || (mode == 2'b10);
    pbit    = ^data;
    if (mode == 2'b10) pbit = ~pbit;
    pbit = pbit ^ pflip;
    if (!started) begin
      fs[s] = 1'b1;
      pm[s] = mode;
      ss[s] = 1'($urandom_range(0, 1));
      si[s] = 1'($urandom_range(0, 1));
      tick();
      fs[s] = 1'b0;
      ss[s] = 1'b0;
    end
    pm[s] = 2'($urandom);
    for (int i = 0; i < db; i++) bits.push_back(data[i]);
    if (has_par) bits.push_back(pbit);
    bits.push_back(stop);
    foreach (bits[i]) begin
      repeat ($urandom_range(0, 2)) begin
        si[s] = 1'($urandom_range(0, 1));
        tick();
      end
      ss[s] = 1'b1;
      si[s] = bits[i];
      tick();
      ss[s] = 1'b0;
    end
    // Now in the LOAD cycle: results must not be visible yet.
    check_val("load.fd_early", fd[s], 1'b0);
    rd[s] = rd_load;
    ss[s] = 1'($urandom_range(0, 1));
    if (bb) begin
      fs[s] = 1'b1;
      pm[s] = bb_mode;
    end
    tick();
    rd[s] = 1'b0;
    ss[s] = 1'b0;
    fs[s] = 1'b0;
    if (rd_load && e_rdy[s]) begin
      e_rdy[s] = 0;
      e_ovr[s] = 0;
    end
    if (!e_rdy[s]) begin
      e_data[s] = data;
      if (mode == 2'b01)      e_perr[s] = ((^data) ^ pbit) != 1'b0;
      else if (mode == 2'b10) e_perr[s] = ((^data) ^ pbit) != 1'b1;
      else                    e_perr[s] = 0;
      e_ferr[s] = !stop;
      e_rdy[s]  = 1;
    end else begin
      e_ovr[s] = 1;
    end
    e_done[s]++;
    $display("[TB] dut%0d frame data=0x%0h mode=%0d pflip=%0d stop=%0d rd_in_load=%0d b2b=%0d",
             s, data, mode, pflip, stop, rd_load, bb);
    check_val("frame.fd", fd[s], 1'b1);
    check_outputs(s, "frame");
    si[s] = 1'($urandom_range(0, 1));
    tick();
    check_val("frame.fd_end", fd[s], 1'b0);
  endtask

  task automatic do_read(input int s);
    rd[s] = 1'b1;
    tick();
    rd[s] = 1'b0;
    if (e_rdy[s]) begin
      e_rdy[s] = 0;
      e_ovr[s] = 0;
    end
    $display("[TB] dut%0d data_read", s);
    check_val("read.ready", rdy[s], e_rdy[s]);
    check_val("read.ovr", ovr[s], e_ovr[s]);
  endtask

  task automatic partial(input int s, input int n);
    fs[s] = 1'b1;
    pm[s] = 2'($urandom);
    tick();
    fs[s] = 1'b0;
    for (int i = 0; i < n; i++) begin
      ss[s] = 1'b1;
      si[s] = 1'($urandom_range(0, 1));
      tick();
    end
    ss[s] = 1'b0;
    $display("[TB] dut%0d partial frame of %0d bits", s, n);
  endtask

  initial begin
    int         s;
    int         pend_s;
    logic [1:0] pend_mode;
    bit         pend;
    for (int i = 0; i < 2; i++) begin
      fs[i] = 0; ss[i] = 0; si[i] = 1; rd[i] = 0; pm[i] = 0; e_done[i] = 0;
    end
    model_reset();
    n_rst = 1'b0;
    tick();
    tick();
    check_outputs(0, "reset8");
    check_outputs(1, "reset5");
    check_val("reset.fd8", fd[0], 1'b0);
    check_val("reset.fd5", fd[1], 1'b0);
    n_rst = 1'b1;
    tick();

    // Directed frames on the 8-bit instance.
    send_frame(0, 9'hA5, 2'b00, 0, 1, 0, 0, 2'b00, 0);
    do_read(0);
    send_frame(0, 9'h3C, 2'b01, 0, 1, 0, 0, 2'b00, 0);
    do_read(0);
    send_frame(0, 9'h3C, 2'b01, 1, 1, 0, 0, 2'b00, 0);
    do_read(0);
    send_frame(0, 9'h55, 2'b00, 0, 0, 0, 0, 2'b00, 0);
    do_read(0);
    send_frame(0, 9'h11, 2'b00, 0, 1, 0, 0, 2'b00, 0);
    send_frame(0, 9'h22, 2'b00, 0, 1, 0, 0, 2'b00, 0);
    check_val("overrun.done_cnt", done_cnt[0], e_done[0]);
    do_read(0);
    partial(0, 4);
    send_frame(0, 9'h0F, 2'b00, 0, 1, 0, 0, 2'b00, 0);
    check_val("restart.done_cnt", done_cnt[0], e_done[0]);
    do_read(0);

    // 5-bit instance, odd parity, then a read in the LOAD cycle of the next frame.
    send_frame(1, 9'b10110, 2'b10, 0, 1, 0, 0, 2'b00, 0);
    send_frame(1, 9'b01001, 2'b10, 0, 1, 1, 0, 2'b00, 0);

    // Back-to-back: frame_start in LOAD.
    send_frame(0, 9'hC3, 2'b01, 0, 1, 1, 1, 2'b10, 0);
    send_frame(0, 9'h7E, 2'b10, 0, 1, 1, 0, 2'b00, 1);

    // Asynchronous reset mid-frame on both instances.
    partial(0, 5);
    partial(1, 3);
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    check_outputs(0, "areset8");
    check_outputs(1, "areset5");
    check_val("areset.fd8", fd[0], 1'b0);
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      ss[0] = 1'b1; ss[1] = 1'b1;
      si[0] = 1'($urandom_range(0, 1));
      si[1] = 1'($urandom_range(0, 1));
      tick();
    end
    ss[0] = 1'b0; ss[1] = 1'b0;
    tick();
    $display("[TB] strobes without frame_start after reset");
    check_val("noframe.done8", done_cnt[0], e_done[0]);
    check_val("noframe.done5", done_cnt[1], e_done[1]);
    check_val("noframe.ready8", rdy[0], 1'b0);
    check_val("noframe.ready5", rdy[1], 1'b0);

    // Random frames.
    pend = 0;
    pend_s = 0;
    pend_mode = 2'b00;
    for (int n = 0; n < 40; n++) begin
      logic [1:0] mode;
      bit         bb;
      bit         started;
      logic [1:0] nmode;
      s       = pend ? pend_s : int'($urandom_range(0, 1));
      mode    = pend ? pend_mode : 2'($urandom);
      started = pend;
      bb      = ($urandom_range(0, 3) == 0);
      nmode   = 2'($urandom);
      send_frame(s, 9'($urandom), mode, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), bb, nmode, started);
      pend      = bb;
      pend_s    = s;
      pend_mode = nmode;
      if (!pend && $urandom_range(0, 1) == 1) do_read(s);
    end
    if (pend) begin
      send_frame(pend_s, 9'($urandom), pend_mode, 0, 1, 0, 0, 2'b00, 1);
    end
    tick();
    check_val("final.done8", done_cnt[0], e_done[0]);
    check_val("final.done5", done_cnt[1], e_done[1]);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
